// File: rtl/instruction_loader_if.sv
// Bus between the byte source / instruction memory side and the program loader.
// The loader sits on the slave modport; the driver of start/rx bytes uses master.
interface instruction_loader_if #(
    parameter int len_addr = 11,
    parameter int len_data = 32
);
    logic                start;
    logic                rx_done;
    logic [7:0]          rx_data;
    logic                mem_wr;
    logic [len_addr-1:0] mem_addr;
    logic [len_data-1:0] mem_data;
    logic                busy;
    logic                done;
    logic                full;
    logic [len_addr:0]   word_count;

    modport master (
        output start, rx_done, rx_data,
        input  mem_wr, mem_addr, mem_data, busy, done, full, word_count
    );

    modport slave (
        input  start, rx_done, rx_data,
        output mem_wr, mem_addr, mem_data, busy, done, full, word_count
    );
endinterface

// File: rtl/instruction_loader.sv
// Assembles a UART byte stream (MSB first) into 32-bit words and writes them to
// sequential instruction-memory addresses until a HALT word or the last address.
module instruction_loader #(
    parameter int len_addr  = 11,
    parameter int len_data  = 32,
    parameter int ram_depth = 2048
) (
    input  logic               clk,
    input  logic               reset,
    instruction_loader_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [len_addr-1:0] LAST_ADDR = len_addr'(ram_depth - 1);

    state_t              r_state;
    logic [1:0]          r_byte_cnt;
    logic                r_mem_wr;
    logic [len_addr-1:0] r_mem_addr;
    logic [len_data-1:0] r_mem_data;
    logic                r_busy;
    logic                r_done;
    logic                r_full;
    logic [len_addr:0]   r_word_count;

    logic                w_halt;
    logic                w_last;
    logic [len_data-1:0] w_shifted;

    assign w_halt    = (r_mem_data[len_data-1 -: 6] == 6'b111111);
    assign w_last    = (r_mem_addr == LAST_ADDR);
    assign w_shifted = {r_mem_data[len_data-9:0], bus.rx_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= 2'd0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_full       <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_mem_wr <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // A byte arriving alongside start is deliberately dropped.
                    if (bus.start) begin
                        r_state      <= S_COLLECT;
                        r_mem_addr   <= '0;
                        r_word_count <= '0;
                        r_byte_cnt   <= 2'd0;
                        r_full       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (bus.rx_done) begin
                        r_mem_data <= w_shifted;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state  <= S_WRITE;
                            r_mem_wr <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_word_count <= r_word_count + 1'b1;
                    if (w_halt || w_last) begin
                        r_state <= S_DONE;
                        r_full  <= ~w_halt;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= S_COLLECT;
                        r_mem_addr <= r_mem_addr + 1'b1;
                        // Byte counter already wrapped to 0, so this byte becomes byte 0.
                        if (bus.rx_done) begin
                            r_mem_data <= w_shifted;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_wr     = r_mem_wr;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_data   = r_mem_data;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.full       = r_full;
    assign bus.word_count = r_word_count;
endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench: a full-size loader and a 4-entry loader share clock and reset.
module tb_instruction_loader;
    logic clk;
    logic reset;

    instruction_loader_if #(.len_addr(11), .len_data(32)) bus_a ();
    instruction_loader_if #(.len_addr(11), .len_data(32)) bus_b ();

    instruction_loader #(.len_addr(11), .len_data(32), .ram_depth(2048)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    instruction_loader #(.len_addr(11), .len_data(32), .ram_depth(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Write log and strobe-width tracking per DUT.
    logic [10:0] wa_addr[$];
    logic [31:0] wa_data[$];
    logic [10:0] wb_addr[$];
    logic [31:0] wb_data[$];
    int run_a = 0, max_run_a = 0, run_b = 0, max_run_b = 0;

    always @(posedge clk) begin
        if (bus_a.mem_wr) begin
            wa_addr.push_back(bus_a.mem_addr);
            wa_data.push_back(bus_a.mem_data);
            run_a = run_a + 1;
            if (run_a > max_run_a) max_run_a = run_a;
        end else begin
            run_a = 0;
        end
        if (bus_b.mem_wr) begin
            wb_addr.push_back(bus_b.mem_addr);
            wb_data.push_back(bus_b.mem_data);
            run_b = run_b + 1;
            if (run_b > max_run_b) max_run_b = run_b;
        end else begin
            run_b = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        bus_a.rx_done = 1'b1;
        bus_a.rx_data = b;
        tick();
        bus_a.rx_done = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        bus_b.rx_done = 1'b1;
        bus_b.rx_data = b;
        tick();
        bus_b.rx_done = 1'b0;
    endtask

    task automatic start_a();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_wr"},   64'(bus_a.mem_wr),     64'd0);
        check({tag, "_addr"}, 64'(bus_a.mem_addr),   64'd0);
        check({tag, "_data"}, 64'(bus_a.mem_data),   64'd0);
        check({tag, "_busy"}, 64'(bus_a.busy),       64'd0);
        check({tag, "_done"}, 64'(bus_a.done),       64'd0);
        check({tag, "_full"}, 64'(bus_a.full),       64'd0);
        check({tag, "_wc"},   64'(bus_a.word_count), 64'd0);
    endtask

    initial begin
        logic [7:0] prog1[8];
        prog1 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
        reset = 1'b1;
        bus_a.start = 1'b0; bus_a.rx_done = 1'b0; bus_a.rx_data = 8'h00;
        bus_b.start = 1'b0; bus_b.rx_done = 1'b0; bus_b.rx_data = 8'h00;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_zero_a("rst");

        // Two-word program ending in HALT.
        start_a();
        check("start_busy", 64'(bus_a.busy), 64'd1);
        for (int i = 0; i < 4; i++) send_a(prog1[i]);
        check("w1_wr",   64'(bus_a.mem_wr),   64'd1);
        check("w1_addr", 64'(bus_a.mem_addr), 64'd0);
        check("w1_data", 64'(bus_a.mem_data), 64'h20080005);
        tick();
        check("w1_wr_off", 64'(bus_a.mem_wr),     64'd0);
        check("w1_wc",     64'(bus_a.word_count), 64'd1);
        check("w1_next",   64'(bus_a.mem_addr),   64'd1);
        for (int i = 4; i < 8; i++) send_a(prog1[i]);
        check("w2_wr",   64'(bus_a.mem_wr),   64'd1);
        check("w2_addr", 64'(bus_a.mem_addr), 64'd1);
        check("w2_data", 64'(bus_a.mem_data), 64'hFC000000);
        tick();
        check("p1_done", 64'(bus_a.done),       64'd1);
        check("p1_busy", 64'(bus_a.busy),       64'd0);
        check("p1_full", 64'(bus_a.full),       64'd0);
        check("p1_wc",   64'(bus_a.word_count), 64'd2);
        check("p1_addr", 64'(bus_a.mem_addr),   64'd1);
        check("p1_nwr",  64'(wa_addr.size()),   64'd2);
        check("p1_width", 64'(max_run_a),       64'd1);

        // Bytes in DONE are ignored.
        send_a(8'h55);
        tick();
        check("done_hold",  64'(bus_a.mem_data), 64'hFC000000);
        check("done_nowr",  64'(wa_addr.size()), 64'd2);

        // Restart from DONE.
        start_a();
        check("rs_done", 64'(bus_a.done),       64'd0);
        check("rs_addr", 64'(bus_a.mem_addr),   64'd0);
        check("rs_wc",   64'(bus_a.word_count), 64'd0);
        check("rs_busy", 64'(bus_a.busy),       64'd1);

        // Back-to-back bytes; fifth byte lands in the WRITE cycle.
        send_a(8'h00); send_a(8'h00); send_a(8'h00); send_a(8'h01);
        check("b2b_wr",   64'(bus_a.mem_wr),   64'd1);
        check("b2b_data", 64'(bus_a.mem_data), 64'h00000001);
        send_a(8'h0A);
        check("b2b_addr", 64'(bus_a.mem_addr), 64'd1);
        check("b2b_wc",   64'(bus_a.word_count), 64'd1);
        // start while busy must not restart the load.
        start_a();
        check("mid_addr", 64'(bus_a.mem_addr), 64'd1);
        send_a(8'h0B); send_a(8'h0C); send_a(8'h0D);
        check("b3_wr",   64'(bus_a.mem_wr),   64'd1);
        check("b3_addr", 64'(bus_a.mem_addr), 64'd1);
        check("b3_data", 64'(bus_a.mem_data), 64'h0A0B0C0D);
        tick();
        send_a(8'hFC); send_a(8'h00); send_a(8'h00); send_a(8'h01);
        check("b4_addr", 64'(bus_a.mem_addr), 64'd2);
        tick();
        check("b4_done", 64'(bus_a.done),       64'd1);
        check("b4_wc",   64'(bus_a.word_count), 64'd3);
        check("log_a3",  64'(wa_addr.size()),   64'd5);
        check("log_d2",  64'(wa_data[2]),       64'h00000001);

        // Reset after two bytes discards the partial word.
        start_a();
        send_a(8'h77); send_a(8'h66);
        reset = 1'b1;
        tick();
        check("mr_wr_rst", 64'(bus_a.mem_wr), 64'd0);
        reset = 1'b0;
        tick();
        check_zero_a("mr");
        check("mr_nowr", 64'(wa_addr.size()), 64'd5);

        // Bytes while IDLE, then start together with a byte that must be dropped.
        send_a(8'hAA); send_a(8'hBB); send_a(8'hCC); send_a(8'hDD);
        tick();
        check("idle_nowr", 64'(wa_addr.size()), 64'd5);
        check("idle_busy", 64'(bus_a.busy),     64'd0);
        bus_a.start = 1'b1;
        send_a(8'h99);
        bus_a.start = 1'b0;
        send_a(8'h12); send_a(8'h34); send_a(8'h56); send_a(8'h78);
        check("il_wr",   64'(bus_a.mem_wr),   64'd1);
        check("il_addr", 64'(bus_a.mem_addr), 64'd0);
        check("il_data", 64'(bus_a.mem_data), 64'h12345678);

        // Memory exhaustion on the 4-entry loader.
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int i = 1; i <= 16; i++) send_b(8'(i));
        tick();
        check("fu_done", 64'(bus_b.done),       64'd1);
        check("fu_full", 64'(bus_b.full),       64'd1);
        check("fu_wc",   64'(bus_b.word_count), 64'd4);
        check("fu_nwr",  64'(wb_addr.size()),   64'd4);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_w;
            exp_w = {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)};
            check($sformatf("fu_addr%0d", i), 64'(wb_addr[i]), 64'(i));
            check($sformatf("fu_data%0d", i), 64'(wb_data[i]), 64'(exp_w));
        end
        send_b(8'h3F);
        tick();
        check("fu_17_nwr",  64'(wb_addr.size()), 64'd4);
        check("fu_17_data", 64'(bus_b.mem_data), 64'h0D0E0F10);
        check("fu_width",   64'(max_run_b),      64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Program-load controller for the instruction memory.
- Receives the program as a byte stream from the UART receiver and assembles each group of 4 bytes (MSB first) into a 32-bit instruction.
- Writes each instruction to sequential addresses starting at 0, using a single-cycle write strobe.
- Stops when it writes a HALT instruction (opcode 6'b111111) or when memory is full. It then reports completion to the debug unit, which releases the pipeline.

Parameters:
- len_addr, 11, instruction memory address width.
- len_data, 32, instruction width; must be 32 (4 bytes per word).
- ram_depth, 2048, number of memory entries; the last writable address is ram_depth-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load from address 0.
- rx_done  input  1  single-cycle pulse; rx_data is valid this cycle.
- rx_data  input  8  received byte.
- mem_wr  output  1  instruction memory write strobe; high for exactly one cycle per word.
- mem_addr  output  len_addr  write address.
- mem_data  output  len_data  assembled instruction.
- busy  output  1  high in COLLECT and WRITE.
- done  output  1  high in DONE.
- full  output  1  load ended by memory exhaustion, not by HALT; valid while done=1.
- word_count  output  len_addr+1  number of words written in the current/last load.

Behaviour:
- States: IDLE, COLLECT, WRITE, DONE. On reset: state IDLE; internal byte counter 0.
- Outputs after reset: mem_wr=0, mem_addr=0, mem_data=0, busy=0, done=0, full=0, word_count=0.
- IDLE:
  - start=1: clear mem_addr, word_count, byte counter and full; go to COLLECT.
  - rx_done is ignored.
- COLLECT, on rx_done:
  - Shift the byte in: mem_data <= {mem_data[23:0], rx_data}.
  - Increment the byte counter (mod 4).
  - If the counter was 3, go to WRITE next cycle.
- WRITE (exactly one cycle):
  - mem_wr=1 with the stable mem_addr and mem_data.
  - word_count increments at the end of the cycle.
  - HALT check is combinational on mem_data[31:26]==6'b111111.
  - If HALT: go to DONE, full=0.
  - Else if mem_addr==ram_depth-1: go to DONE, full=1.
  - Else: mem_addr increments and the state returns to COLLECT.
- rx_done during WRITE:
  - If the next state is COLLECT, the byte is accepted as byte 0 of the next word (shifted in, counter=1). No byte is lost.
  - If the next state is DONE, the byte is dropped.
- Write latency: mem_wr rises in the cycle after the 4th rx_done.
- DONE:
  - done=1; mem_addr, mem_data, full and word_count hold; rx_done is ignored.
  - start=1: re-initialise exactly as from IDLE and go to COLLECT.
- start while busy: ignored; no restart.
- Simultaneous start and rx_done in IDLE or DONE: start is taken, the byte is dropped.
- reset mid-load: back to IDLE within one cycle, with all outputs at reset values.
  - A partially assembled word is discarded and is never written.
  - mem_wr is never high in the cycle after reset is sampled.
- No timeout; COLLECT waits indefinitely for bytes.

Test Plan:
- Reset, start, then bytes 20 08 00 05 FC 00 00 00 -> two WRITE cycles.
  - Write 1: mem_addr=0, mem_data=32'h20080005.
  - Write 2: mem_addr=1, mem_data=32'hFC000000.
  - Then done=1, full=0, word_count=2, each mem_wr exactly 1 cycle wide.
- Bytes 00 00 00 01 sent back-to-back with a 5th byte 00 arriving in the WRITE cycle.
  - Write of 32'h00000001 at addr 0.
  - Next word then completes after only 3 more bytes.
- ram_depth=4 build, 16 non-HALT bytes -> 4 writes to addresses 0..3, then done=1, full=1, word_count=4. A 17th byte is ignored.
- Assert reset after 2 bytes of the first word -> no mem_wr ever, all outputs 0, state IDLE. A new start then loads from address 0 correctly.
- start pulse mid-load after 1 word -> load continues undisturbed, 2nd word at addr 1.
  - start pulse in DONE -> done=0, mem_addr=0, word_count=0, new load proceeds.
- Bytes while IDLE (before any start) -> mem_wr stays 0. A following start plus 4 bytes writes to addr 0 with only those 4 bytes.
